nibble_serial_add_ctrl: RTL and testbench

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

---
 rtl/nibble_serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add controller: drives an external 4-bit adder slice for WIDTH/4 cycles per operand pair.
// Optional subtract mode is enabled by defining NIBBLE_SERIAL_ADD_CTRL_SUB_EN.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
`ifdef NIBBLE_SERIAL_ADD_CTRL_SUB_EN
    input  logic             sub_i,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] y_o,
    output logic             co_o,
    output logic [3:0]       add_a_o,
    output logic [3:0]       add_b_o,
    output logic             add_ci_o,
    input  logic [3:0]       add_s_i,
    input  logic             add_co_i
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             sub_q, sub_d;
    logic             sub_in;
    logic [3:0]       nib_a, nib_b;

`ifdef NIBBLE_SERIAL_ADD_CTRL_SUB_EN
    assign sub_in = sub_i;
`else
    assign sub_in = 1'b0;
`endif

    // Nibble k of each operand register, selected by the running index.
    assign nib_a = 4'(a_q >> {idx_q, 2'b00});
    assign nib_b = 4'(b_q >> {idx_q, 2'b00});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            sub_q   <= sub_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        y_d         = y_q;
        sub_d       = sub_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        y_o         = '0;
        co_o        = 1'b0;
        add_a_o     = 4'h0;
        add_b_o     = 4'h0;
        add_ci_o    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    sub_d   = sub_in;
                    idx_d   = '0;
                    // Subtract is A + ~B + 1, so the carry chain starts at 1.
                    carry_d = sub_in;
                    state_d = RUN;
                end
            end
            RUN: begin
                add_a_o  = nib_a;
                add_b_o  = sub_q ? ~nib_b : nib_b;
                add_ci_o = carry_q;
                y_d[{idx_q, 2'b00} +: 4] = add_s_i;
                carry_d  = add_co_i;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                y_o         = y_q;
                co_o        = carry_q;
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (WIDTH=16) with a behavioural 4-bit adder slice on ADD_*.
module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, co;
    logic [15:0] a, b, y;
    logic [3:0]  add_a, add_b, add_s;
    logic        add_ci, add_co;
`ifdef NIBBLE_SERIAL_ADD_CTRL_SUB_EN
    logic        sub;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Behavioural adder slice.
    assign {add_co, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_ci);

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b),
`ifdef NIBBLE_SERIAL_ADD_CTRL_SUB_EN
        .sub_i(sub),
`endif
        .out_valid_o(out_valid), .out_ready_i(out_ready), .y_o(y), .co_o(co),
        .add_a_o(add_a), .add_b_o(add_b), .add_ci_o(add_ci),
        .add_s_i(add_s), .add_co_i(add_co)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one pair from IDLE, scramble the inputs after accept, and stop in DONE.
    // Accept edge plus N=4 RUN edges: OUT_VALID is seen 4 edges after the accept edge.
    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic [15:0] ey, input logic eco);
        int  n;
        logic rdy_seen;
        a = ta; b = tb_; in_valid = 1'b1;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; a = ~ta; b = 16'h5A5A;
        n = 0; rdy_seen = 1'b0;
        while (!out_valid && n < 20) begin
            if (in_ready) rdy_seen = 1'b1;
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd4);
        chk({tag, "_busy"}, 32'(rdy_seen | in_ready), 32'd0);
        chk({tag, "_y"}, 32'(y), 32'(ey));
        chk({tag, "_co"}, 32'(co), 32'(eco));
    endtask

    initial begin
        int          n, gap;
        logic        ok;
        logic [15:0] ra, rb;
        logic [16:0] s;
        logic [15:0] opa;
        logic [3:0]  ci_exp;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
`ifdef NIBBLE_SERIAL_ADD_CTRL_SUB_EN
        sub = 1'b0;
`endif
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y_co", 32'({co, y}), 32'd0);
        chk("rst_add", 32'({add_a, add_b, add_ci}), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Reset wins over a simultaneous offer.
        rst = 1'b1; in_valid = 1'b1; a = 16'h0003; b = 16'h0004;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_prio_ready", 32'(in_ready), 32'd1);
        chk("rst_prio_add", 32'({add_a, add_b, add_ci}), 32'd0);

        // 0x1234 + 0x0FFF: nibble carries 1,1,1,0 -> carry-ins 0,1,1,1.
        a = 16'h1234; b = 16'h0FFF; in_valid = 1'b1;
        opa = 16'h1234; ci_exp = 4'b1110;
        tick();
        in_valid = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            chk("t1_ci", 32'(add_ci), 32'(ci_exp[k]));
            chk("t1_add_a", 32'(add_a), 32'(opa[4*k +: 4]));
            chk("t1_busy", 32'({in_ready, out_valid}), 32'd0);
            tick();
        end
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_y", 32'(y), 32'h2233);
        chk("t1_co", 32'(co), 32'd0);
        tick();
        chk("t1_back_idle", 32'({in_ready, out_valid}), 32'b10);

        do_op("t2", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        tick();

        // Consumer stalls for 10 cycles.
        out_ready = 1'b0;
        do_op("t3", 16'h00FF, 16'h0001, 16'h0100, 1'b0);
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!(out_valid && !in_ready && y == 16'h0100 && !co)) ok = 1'b0;
        end
        chk("t3_hold", 32'(ok), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("t3_release", 32'({in_ready, out_valid}), 32'b10);

        // Reset during the 2nd RUN cycle aborts the operation.
        a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t4_in_run", 32'(add_a), 32'hA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_abort_idle", 32'({in_ready, out_valid}), 32'b10);
        chk("t4_abort_add", 32'({add_a, add_b, add_ci}), 32'd0);
        ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid) ok = 1'b0;
        end
        chk("t4_no_valid", 32'(ok), 32'd1);
        do_op("t4b", 16'h0001, 16'h0002, 16'h0003, 1'b0);
        tick();

        // Back-to-back with IN_VALID held high.
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            a = ra; b = rb;
            s = 17'(ra) + 17'(rb);
            tick();
            n = 0;
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            chk("b2b_y", 32'(y), 32'(s[15:0]));
            chk("b2b_co", 32'(co), 32'(s[16]));
            a = 16'h0F0F; b = 16'hF0F0;
            tick();
            gap = n + 2;
            chk("b2b_gap", 32'(gap + (in_ready ? 0 : 100)), 32'd6);
        end
        in_valid = 1'b0;
        tick(); tick(); tick(); tick(); tick(); tick();

`ifdef NIBBLE_SERIAL_ADD_CTRL_SUB_EN
        sub = 1'b1;
        do_op("sub1", 16'h0005, 16'h0007, 16'hFFFE, 1'b0);
        tick();
        do_op("sub2", 16'h0007, 16'h0005, 16'h0002, 1'b1);
        tick();
        sub = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
